// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_pkg
// Description : Shared VGA timing and framebuffer geometry constants used by
//               the timing generator, draw engine and VRAM arbiter. The
//               160x120 framebuffer is upscaled 4x in both directions to fill
//               a 640x480 display.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

    localparam int H_ACTIVE = 640;   // visible pixels per line
    localparam int H_TOTAL  = 800;   // clocks per line
    localparam int V_ACTIVE = 480;   // visible lines
    localparam int V_TOTAL  = 525;   // lines per frame
    localparam int FB_W     = 160;   // framebuffer columns
    localparam int FB_H     = 120;   // framebuffer rows
    localparam int ADDR_W   = 15;    // RAM word address width

    // Number of valid framebuffer words; anything at or above is out of range.
    localparam logic [ADDR_W-1:0] FB_WORDS = ADDR_W'(FB_W * FB_H);

    // Round-robin pointer: which client wins when both request together.
    typedef enum logic [0:0] {
        RR_C0 = 1'b0,
        RR_C1 = 1'b1
    } rr_ptr_e;

    // Linear framebuffer address: row*160 + col, with the multiply expressed
    // as row*128 + row*32.
    function automatic logic [ADDR_W-1:0] fb_addr(input logic [6:0] row,
                                                  input logic [7:0] col);
        logic [ADDR_W-1:0] row_w;
        row_w   = {8'd0, row};
        fb_addr = (row_w << 7) + (row_w << 5) + {7'd0, col};
    endfunction

endpackage
`default_nettype wire

// File: rtl/vram_fetch_addr.sv
`default_nettype none
// ============================================================================
// Module      : vram_fetch_addr
// Description : Display-fetch slot decode. A display read is issued two
//               clocks ahead of the 4-pixel group it feeds, so the decode looks
//               at h_count+2 (wrapping at the line end) and, on the last-but-
//               one clock of a line, at the next line.
// Ports       : h_count_i    in  10      current pixel column
//               v_count_i    in  10      current line
//               disp_slot_o  out 1       this cycle belongs to display fetch
//               disp_addr_o  out ADDR_W  framebuffer word to fetch
// Revision    : 1.0 - initial release
// ============================================================================
module vram_fetch_addr
    import vga_pkg::*;
(
    input  logic [9:0]        h_count_i,
    input  logic [9:0]        v_count_i,
    output logic              disp_slot_o,
    output logic [ADDR_W-1:0] disp_addr_o
);

    localparam logic [10:0] H_TOTAL_L   = 11'(H_TOTAL);
    localparam logic [10:0] H_ACTIVE_L  = 11'(H_ACTIVE);
    localparam logic [9:0]  H_WRAP_L    = 10'(H_TOTAL - 2);
    localparam logic [9:0]  V_LAST_L    = 10'(V_TOTAL - 1);
    localparam logic [9:0]  V_ACTIVE_L  = 10'(V_ACTIVE);

    logic [10:0] h_sum;
    logic [10:0] h_ahead;   // (h_count + 2) mod H_TOTAL
    logic [9:0]  v_next;
    logic [9:0]  line;      // line the fetched pixel will be shown on

    always_comb begin
        h_sum   = {1'b0, h_count_i} + 11'd2;
        h_ahead = (h_sum >= H_TOTAL_L) ? (h_sum - H_TOTAL_L) : h_sum;

        v_next  = (v_count_i == V_LAST_L) ? 10'd0 : (v_count_i + 10'd1);
        // Only h_count = H_TOTAL-2 makes h_ahead wrap to 0, so only that cycle
        // fetches for the following line.
        line    = (h_count_i == H_WRAP_L) ? v_next : v_count_i;

        // h_ahead < H_ACTIVE is the same as column k < FB_W.
        disp_slot_o = (h_ahead[1:0] == 2'b00) &&
                      (h_ahead < H_ACTIVE_L) &&
                      (line < V_ACTIVE_L);

        disp_addr_o = fb_addr(line[8:2], h_ahead[9:2]);
    end

endmodule
`default_nettype wire

// File: rtl/vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : vram_arbiter
// Description : Shares one single-port synchronous-read VRAM between display
//               scan-out and two host clients. Display fetch always wins its
//               slot; remaining cycles go to the clients round-robin. Also
//               registers the fetched pixel and drives the final rgb.
// Ports       : clk_25     in  1       pixel clock
//               rst_n      in  1       synchronous active-low reset
//               h_count    in  10      pixel column from timing generator
//               v_count    in  10      line from timing generator
//               rgb        out 8       pixel to DAC, 0 outside active area
//               ram_addr   out ADDR_W  RAM address
//               ram_we     out 1       RAM write enable
//               ram_wdata  out 8       RAM write data
//               ram_rdata  in  8       RAM read data (1 clk after address)
//               cN_req     in  1       client request, held until ack
//               cN_we      in  1       1 = write, 0 = read
//               cN_addr    in  ADDR_W  client word address
//               cN_wdata   in  8       client write data
//               cN_ack     out 1       access issued to RAM this cycle
//               cN_rvalid  out 1       read data valid (cycle after read ack)
//               cN_rdata   out 8       read data
// Revision    : 1.0 - initial release
// ============================================================================
module vram_arbiter
    import vga_pkg::*;
(
    input  logic              clk_25,
    input  logic              rst_n,
    input  logic [9:0]        h_count,
    input  logic [9:0]        v_count,
    output logic [7:0]        rgb,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [7:0]        ram_wdata,
    input  logic [7:0]        ram_rdata,
    input  logic              c0_req,
    input  logic              c0_we,
    input  logic [ADDR_W-1:0] c0_addr,
    input  logic [7:0]        c0_wdata,
    output logic              c0_ack,
    output logic              c0_rvalid,
    output logic [7:0]        c0_rdata,
    input  logic              c1_req,
    input  logic              c1_we,
    input  logic [ADDR_W-1:0] c1_addr,
    input  logic [7:0]        c1_wdata,
    output logic              c1_ack,
    output logic              c1_rvalid,
    output logic [7:0]        c1_rdata
);

    localparam logic [9:0] H_ACTIVE_L = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACTIVE_L = 10'(V_ACTIVE);

    logic              disp_slot;
    logic [ADDR_W-1:0] disp_addr;

    logic              req0;
    logic              req1;
    logic              grant0;
    logic              grant1;
    logic [ADDR_W-1:0] sel_addr;
    logic              sel_we;
    logic [7:0]        sel_wdata;
    logic              sel_in_range;

    rr_ptr_e           rr_q;
    rr_ptr_e           rr_d;
    logic [7:0]        pix_q;        // pixel shown for the current 4-pixel group
    logic              disp_pend_q;  // ram_rdata holds a display fetch this cycle
    logic              rd0_q;        // client 0 read data on ram_rdata this cycle
    logic              rd1_q;
    logic              rd_oor_q;     // pending read was out of range

    vram_fetch_addr u_fetch_addr (
        .h_count_i   (h_count),
        .v_count_i   (v_count),
        .disp_slot_o (disp_slot),
        .disp_addr_o (disp_addr)
    );

    // ------------------------------------------------------------------
    // Client arbitration. Requests are masked while reset is asserted so a
    // client holding req through reset sees no ack until release.
    // ------------------------------------------------------------------
    always_comb begin
        req0   = c0_req & rst_n;
        req1   = c1_req & rst_n;
        grant0 = 1'b0;
        grant1 = 1'b0;

        if (!disp_slot) begin
            if (req0 && req1) begin
                if (rr_q == RR_C0) grant0 = 1'b1;
                else               grant1 = 1'b1;
            end else if (req0) begin
                grant0 = 1'b1;
            end else if (req1) begin
                grant1 = 1'b1;
            end
        end

        rr_d = rr_q;
        if (grant0)      rr_d = RR_C1;
        else if (grant1) rr_d = RR_C0;

        sel_addr     = grant1 ? c1_addr  : c0_addr;
        sel_we       = grant1 ? c1_we    : c0_we;
        sel_wdata    = grant1 ? c1_wdata : c0_wdata;
        sel_in_range = (sel_addr < FB_WORDS);

        ram_addr  = disp_slot ? disp_addr : sel_addr;
        // Out-of-range writes are acked but never reach the RAM.
        ram_we    = (grant0 | grant1) & sel_we & sel_in_range;
        ram_wdata = sel_wdata;

        c0_ack = grant0;
        c1_ack = grant1;
    end

    // ------------------------------------------------------------------
    // Pipeline state: rr pointer, display pixel register, read-return pipe.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_25) begin
        if (!rst_n) begin
            rr_q        <= RR_C0;
            pix_q       <= 8'd0;
            disp_pend_q <= 1'b0;
            rd0_q       <= 1'b0;
            rd1_q       <= 1'b0;
            rd_oor_q    <= 1'b0;
        end else begin
            rr_q        <= rr_d;
            disp_pend_q <= disp_slot;
            // Fetch issued at 4k-2 returns at 4k-1; loading here makes pix_q
            // valid exactly for h_count 4k..4k+3.
            if (disp_pend_q) pix_q <= ram_rdata;
            rd0_q    <= grant0 & ~c0_we;
            rd1_q    <= grant1 & ~c1_we;
            // At most one grant per cycle, so one range flag serves both.
            rd_oor_q <= ~sel_in_range;
        end
    end

    // An in-flight read whose return cycle coincides with reset is dropped.
    assign c0_rvalid = rd0_q & rst_n;
    assign c1_rvalid = rd1_q & rst_n;
    assign c0_rdata  = (rd0_q && !rd_oor_q) ? ram_rdata : 8'd0;
    assign c1_rdata  = (rd1_q && !rd_oor_q) ? ram_rdata : 8'd0;

    assign rgb = ((h_count < H_ACTIVE_L) && (v_count < V_ACTIVE_L)) ? pix_q : 8'd0;

endmodule
`default_nettype wire

// File: tb/tb_vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_vram_arbiter
// Description : Directed self-checking bench for vram_arbiter with a simple
//               synchronous-read RAM model and a preload port.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vram_arbiter;
    import vga_pkg::*;

    logic              clk_25 = 1'b0;
    logic              rst_n;
    logic [9:0]        h_count;
    logic [9:0]        v_count;
    logic [7:0]        rgb;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [7:0]        ram_wdata;
    logic [7:0]        ram_rdata;
    logic              c0_req, c0_we, c0_ack, c0_rvalid;
    logic [ADDR_W-1:0] c0_addr;
    logic [7:0]        c0_wdata, c0_rdata;
    logic              c1_req, c1_we, c1_ack, c1_rvalid;
    logic [ADDR_W-1:0] c1_addr;
    logic [7:0]        c1_wdata, c1_rdata;

    logic              pl_we;
    logic [ADDR_W-1:0] pl_addr;
    logic [7:0]        pl_data;
    logic [7:0]        mem [0:32767];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk_25 = ~clk_25;

    vram_arbiter dut (
        .clk_25    (clk_25),
        .rst_n     (rst_n),
        .h_count   (h_count),
        .v_count   (v_count),
        .rgb       (rgb),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .c0_req    (c0_req),
        .c0_we     (c0_we),
        .c0_addr   (c0_addr),
        .c0_wdata  (c0_wdata),
        .c0_ack    (c0_ack),
        .c0_rvalid (c0_rvalid),
        .c0_rdata  (c0_rdata),
        .c1_req    (c1_req),
        .c1_we     (c1_we),
        .c1_addr   (c1_addr),
        .c1_wdata  (c1_wdata),
        .c1_ack    (c1_ack),
        .c1_rvalid (c1_rvalid),
        .c1_rdata  (c1_rdata)
    );

    // Full 15-bit RAM so an address past the framebuffer would really land.
    always @(posedge clk_25) begin
        if (pl_we)       mem[pl_addr]  <= pl_data;
        else if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    task automatic next_cycle();
        @(posedge clk_25);
        #1;
    endtask

    task automatic preload(input logic [ADDR_W-1:0] a, input logic [7:0] d);
        next_cycle();
        pl_we   = 1'b1;
        pl_addr = a;
        pl_data = d;
        next_cycle();
        pl_we   = 1'b0;
    endtask

    task automatic test_reset();
        h_count = 10'd100; v_count = 10'd0;
        c0_req = 1'b1; c0_we = 1'b1; c0_addr = 15'd10; c0_wdata = 8'h77;
        for (int i = 0; i < 3; i++) begin
            next_cycle(); #2;
            n_cmp++; if (rgb !== 8'h00) begin n_err++; $display("FAIL reset_rgb[%0d]: got %h want 00", i, rgb); end
            n_cmp++; if (c0_ack !== 1'b0) begin n_err++; $display("FAIL reset_ack[%0d]: got %b want 0", i, c0_ack); end
            n_cmp++; if (ram_we !== 1'b0) begin n_err++; $display("FAIL reset_we[%0d]: got %b want 0", i, ram_we); end
        end
        next_cycle(); rst_n = 1'b1; #2;
        n_cmp++; if (c0_ack !== 1'b1) begin n_err++; $display("FAIL reset_release_ack: got %b want 1", c0_ack); end
        n_cmp++; if (ram_addr !== 15'd10) begin n_err++; $display("FAIL reset_release_addr: got %0d want 10", ram_addr); end
        next_cycle(); c0_req = 1'b0;
        // rr pointer now at client 1
    endtask

    task automatic test_scanout();
        v_count = 10'd0;
        for (int h = 10; h <= 24; h++) begin
            next_cycle(); h_count = 10'(h); #2;
            if (h == 18) begin
                n_cmp++; if (ram_addr !== 15'd5) begin n_err++; $display("FAIL scan_issue_addr: got %0d want 5", ram_addr); end
                n_cmp++; if (ram_we !== 1'b0) begin n_err++; $display("FAIL scan_issue_we: got %b want 0", ram_we); end
            end
            if (h == 19) begin
                n_cmp++; if (rgb !== 8'h11) begin n_err++; $display("FAIL scan_rgb_h19: got %h want 11", rgb); end
            end
            if (h >= 20 && h <= 23) begin
                n_cmp++; if (rgb !== 8'hA5) begin n_err++; $display("FAIL scan_rgb_h%0d: got %h want a5", h, rgb); end
            end
            if (h == 24) begin
                n_cmp++; if (rgb !== 8'h22) begin n_err++; $display("FAIL scan_rgb_h24: got %h want 22", rgb); end
            end
        end
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            h_count = (i == 0) ? 10'd640 : (i == 1) ? 10'd700 : 10'd799; #2;
            n_cmp++; if (rgb !== 8'h00) begin n_err++; $display("FAIL scan_hblank_h%0d: got %h want 00", h_count, rgb); end
        end
        next_cycle(); v_count = 10'd480; h_count = 10'd100; #2;
        n_cmp++; if (rgb !== 8'h00) begin n_err++; $display("FAIL scan_vblank_rgb: got %h want 00", rgb); end
        // h=18 would be a display slot on a visible line; on line 480 it is free.
        next_cycle(); h_count = 10'd18; c1_req = 1'b1; c1_we = 1'b0; c1_addr = 15'd5; #2;
        n_cmp++; if (c1_ack !== 1'b1) begin n_err++; $display("FAIL vblank_no_slot_ack: got %b want 1", c1_ack); end
        next_cycle(); c1_req = 1'b0; h_count = 10'd19; #2;
        n_cmp++; if (c1_rvalid !== 1'b1 || c1_rdata !== 8'hA5) begin n_err++; $display("FAIL vblank_read: rvalid %b rdata %h want 1 a5", c1_rvalid, c1_rdata); end
        // rr pointer now at client 0
    endtask

    task automatic test_line_wrap();
        next_cycle(); h_count = 10'd798; v_count = 10'd3; #2;
        n_cmp++; if (ram_addr !== 15'd160) begin n_err++; $display("FAIL wrap_addr_v3: got %0d want 160", ram_addr); end
        n_cmp++; if (ram_we !== 1'b0) begin n_err++; $display("FAIL wrap_we_v3: got %b want 0", ram_we); end
        next_cycle(); v_count = 10'd524; #2;
        n_cmp++; if (ram_addr !== 15'd0) begin n_err++; $display("FAIL wrap_addr_v524: got %0d want 0", ram_addr); end
        next_cycle(); h_count = 10'd2; v_count = 10'd9; #2;
        n_cmp++; if (ram_addr !== 15'd321) begin n_err++; $display("FAIL slot_addr_v9h2: got %0d want 321", ram_addr); end
        // Line 479 wrapping into 480 has no display fetch: client gets the cycle.
        next_cycle(); h_count = 10'd798; v_count = 10'd479;
        c1_req = 1'b1; c1_we = 1'b0; c1_addr = 15'd6; #2;
        n_cmp++; if (c1_ack !== 1'b1) begin n_err++; $display("FAIL wrap_v479_ack: got %b want 1", c1_ack); end
        next_cycle(); c1_req = 1'b0; h_count = 10'd799; #2;
        n_cmp++; if (c1_rvalid !== 1'b1 || c1_rdata !== 8'h22) begin n_err++; $display("FAIL wrap_v479_read: rvalid %b rdata %h want 1 22", c1_rvalid, c1_rdata); end
        // rr pointer at client 0
    endtask

    task automatic test_contention();
        next_cycle(); h_count = 10'd700; v_count = 10'd500;
        c0_req = 1'b1; c0_we = 1'b1; c0_addr = 15'd100; c0_wdata = 8'h11;
        c1_req = 1'b1; c1_we = 1'b1; c1_addr = 15'd101; c1_wdata = 8'h22; #2;
        n_cmp++; if (c0_ack !== 1'b1 || c1_ack !== 1'b0) begin n_err++; $display("FAIL cont_cyc1: ack0 %b ack1 %b want 1 0", c0_ack, c1_ack); end
        n_cmp++; if (ram_addr !== 15'd100 || ram_we !== 1'b1) begin n_err++; $display("FAIL cont_cyc1_ram: addr %0d we %b want 100 1", ram_addr, ram_we); end
        // c0 immediately issues a new request; pointer now favours c1.
        next_cycle(); c0_addr = 15'd102; c0_wdata = 8'h33; #2;
        n_cmp++; if (c0_ack !== 1'b0 || c1_ack !== 1'b1) begin n_err++; $display("FAIL cont_cyc2: ack0 %b ack1 %b want 0 1", c0_ack, c1_ack); end
        n_cmp++; if (ram_addr !== 15'd101) begin n_err++; $display("FAIL cont_cyc2_addr: got %0d want 101", ram_addr); end
        next_cycle(); c1_req = 1'b0; #2;
        n_cmp++; if (c0_ack !== 1'b1 || ram_addr !== 15'd102) begin n_err++; $display("FAIL cont_cyc3: ack0 %b addr %0d want 1 102", c0_ack, ram_addr); end
        next_cycle(); c0_req = 1'b0;
        // Active line: h=2 is a display slot, so the request waits one clock.
        next_cycle(); h_count = 10'd2; v_count = 10'd10;
        c0_req = 1'b1; c0_we = 1'b1; c0_addr = 15'd103; c0_wdata = 8'h44; #2;
        n_cmp++; if (c0_ack !== 1'b0 || ram_we !== 1'b0) begin n_err++; $display("FAIL active_wait: ack %b we %b want 0 0", c0_ack, ram_we); end
        n_cmp++; if (ram_addr !== 15'd321) begin n_err++; $display("FAIL active_disp_addr: got %0d want 321", ram_addr); end
        next_cycle(); h_count = 10'd3; #2;
        n_cmp++; if (c0_ack !== 1'b1 || ram_addr !== 15'd103) begin n_err++; $display("FAIL active_grant: ack %b addr %0d want 1 103", c0_ack, ram_addr); end
        next_cycle(); c0_req = 1'b0;
    endtask

    task automatic test_read();
        next_cycle(); h_count = 10'd700; v_count = 10'd500;
        c1_req = 1'b1; c1_we = 1'b0; c1_addr = 15'd161; #2;
        n_cmp++; if (c1_ack !== 1'b1 || ram_addr !== 15'd161) begin n_err++; $display("FAIL read_c1_ack: ack %b addr %0d want 1 161", c1_ack, ram_addr); end
        next_cycle(); c1_req = 1'b0; #2;
        n_cmp++; if (c1_rvalid !== 1'b1 || c1_rdata !== 8'h3C) begin n_err++; $display("FAIL read_c1_data: rvalid %b rdata %h want 1 3c", c1_rvalid, c1_rdata); end
        n_cmp++; if (c0_rvalid !== 1'b0) begin n_err++; $display("FAIL read_c0_quiet: got %b want 0", c0_rvalid); end
        next_cycle(); c0_req = 1'b1; c0_we = 1'b0; c0_addr = 15'd102;
        next_cycle(); c0_req = 1'b0; #2;
        n_cmp++; if (c0_rvalid !== 1'b1 || c0_rdata !== 8'h33) begin n_err++; $display("FAIL read_back_102: rvalid %b rdata %h want 1 33", c0_rvalid, c0_rdata); end
    endtask

    task automatic test_out_of_range();
        next_cycle(); c0_req = 1'b1; c0_we = 1'b1; c0_addr = 15'd19200; c0_wdata = 8'hEE; #2;
        n_cmp++; if (c0_ack !== 1'b1 || ram_we !== 1'b0) begin n_err++; $display("FAIL oor_write: ack %b we %b want 1 0", c0_ack, ram_we); end
        next_cycle(); c0_we = 1'b0; #2;
        n_cmp++; if (c0_ack !== 1'b1) begin n_err++; $display("FAIL oor_read_ack: got %b want 1", c0_ack); end
        next_cycle(); c0_req = 1'b0; #2;
        n_cmp++; if (c0_rvalid !== 1'b1 || c0_rdata !== 8'h00) begin n_err++; $display("FAIL oor_read: rvalid %b rdata %h want 1 00", c0_rvalid, c0_rdata); end
        n_cmp++; if (mem[19200] !== 8'h5A) begin n_err++; $display("FAIL oor_ram_unchanged: got %h want 5a", mem[19200]); end
    endtask

    task automatic test_reset_midread();
        next_cycle(); c0_req = 1'b1; c0_we = 1'b0; c0_addr = 15'd161; #2;
        n_cmp++; if (c0_ack !== 1'b1) begin n_err++; $display("FAIL midrst_ack: got %b want 1", c0_ack); end
        next_cycle(); rst_n = 1'b0; c0_addr = 15'd5; #2;
        n_cmp++; if (c0_rvalid !== 1'b0 || c0_ack !== 1'b0) begin n_err++; $display("FAIL midrst_suppress: rvalid %b ack %b want 0 0", c0_rvalid, c0_ack); end
        next_cycle(); rst_n = 1'b1; #2;
        n_cmp++; if (c0_ack !== 1'b1) begin n_err++; $display("FAIL midrst_resume_ack: got %b want 1", c0_ack); end
        next_cycle(); c0_req = 1'b0; #2;
        n_cmp++; if (c0_rvalid !== 1'b1 || c0_rdata !== 8'hA5) begin n_err++; $display("FAIL midrst_resume_read: rvalid %b rdata %h want 1 a5", c0_rvalid, c0_rdata); end
    endtask

    initial begin
        rst_n = 1'b0;
        h_count = 10'd700; v_count = 10'd500;
        c0_req = 1'b0; c0_we = 1'b0; c0_addr = '0; c0_wdata = '0;
        c1_req = 1'b0; c1_we = 1'b0; c1_addr = '0; c1_wdata = '0;
        pl_we = 1'b0; pl_addr = '0; pl_data = '0;

        preload(15'd4, 8'h11);
        preload(15'd5, 8'hA5);
        preload(15'd6, 8'h22);
        preload(15'd161, 8'h3C);
        preload(15'd19200, 8'h5A);

        test_reset();
        test_scanout();
        test_line_wrap();
        test_contention();
        test_read();
        test_out_of_range();
        test_reset_midread();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
